// File: rtl/trace_driver.sv
// trace_driver: multi-channel strided trace generator collecting per-channel hit/miss statistics
module trace_driver #(
    parameter int NCORES     = 2,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 10000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        stride,
    input  logic [CNT_W-1:0]         num_req,
    output logic [NCORES-1:0]        req_valid,
    output logic [NCORES*ADDR_W-1:0] req_addr,
    input  logic [NCORES-1:0]        req_ready,
    input  logic [NCORES-1:0]        resp_valid,
    input  logic [NCORES-1:0]        resp_hit,
    output logic [NCORES*CNT_W-1:0]  hit_count,
    output logic [NCORES*CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} gstate_t;
    typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT, C_DONE} cstate_t;

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] TLIM = CNT_W'(MAX_CYCLES - 1);

    gstate_t           gs;
    cstate_t           cs [NCORES];
    logic [CNT_W-1:0]  rcnt [NCORES];
    logic [CNT_W-1:0]  nreq;
    logic [ADDR_W-1:0] step;
    logic              all_done;
    logic              tmo;
    logic              go;

    // run completes once every channel has retired its last response
    always_comb begin
        all_done = 1'b1;
        for (int c = 0; c < NCORES; c++) all_done = all_done & (cs[c] == C_DONE);
    end

    assign tmo = (gs == RUN) && (cycle_count == TLIM);
    assign go  = start && (gs != RUN);

    // global run control plus per-channel issue/wait sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gs          <= IDLE;
            nreq        <= '0;
            step        <= '0;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            req_valid   <= '0;
            req_addr    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int c = 0; c < NCORES; c++) begin
                cs[c]   <= C_IDLE;
                rcnt[c] <= '0;
            end
        end else if (go) begin
            gs          <= RUN;
            nreq        <= num_req;
            step        <= ADDR_W'(NCORES) * stride;
            cycle_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
            req_valid   <= {NCORES{num_req != '0}};
            for (int c = 0; c < NCORES; c++) begin
                cs[c]                       <= (num_req == '0) ? C_DONE : C_ISSUE;
                rcnt[c]                     <= '0;
                req_addr[c*ADDR_W +: ADDR_W] <= base_addr + ADDR_W'(c) * stride;
            end
        end else if (gs == RUN) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (tmo || all_done) begin
                gs        <= FINISH;
                busy      <= 1'b0;
                done      <= 1'b1;
                timeout   <= tmo;
                req_valid <= '0;
                for (int c = 0; c < NCORES; c++) cs[c] <= C_DONE;
            end else begin
                for (int c = 0; c < NCORES; c++) begin
                    case (cs[c])
                        C_ISSUE: if (req_ready[c]) begin
                            cs[c]        <= C_WAIT;
                            req_valid[c] <= 1'b0;
                        end
                        C_WAIT: if (resp_valid[c]) begin
                            if (resp_hit[c])
                                hit_count[c*CNT_W +: CNT_W] <= (hit_count[c*CNT_W +: CNT_W] == CMAX) ?
                                    CMAX : hit_count[c*CNT_W +: CNT_W] + CNT_W'(1);
                            else
                                miss_count[c*CNT_W +: CNT_W] <= (miss_count[c*CNT_W +: CNT_W] == CMAX) ?
                                    CMAX : miss_count[c*CNT_W +: CNT_W] + CNT_W'(1);
                            rcnt[c] <= rcnt[c] + CNT_W'(1);
                            if (rcnt[c] == nreq - CNT_W'(1)) begin
                                cs[c] <= C_DONE;
                            end else begin
                                cs[c]                        <= C_ISSUE;
                                req_valid[c]                 <= 1'b1;
                                req_addr[c*ADDR_W +: ADDR_W] <= req_addr[c*ADDR_W +: ADDR_W] + step;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
